// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//
// Time-multiplexed driver for a 4-digit, common-anode, 7-segment display that
// shows the result of the BCD subtraction datapath.
//
// The scan rate comes from a free-running prescaler. It is used as a clock
// enable, so no derived clock net exists. At the start of every frame the
// block takes a snapshot of {digits, sign, blank_lz}. All four digits of that
// frame are drawn from this one snapshot. After each scan step the anodes stay
// off for BLANK clocks so the previous digit's segments do not ghost onto the
// next anode.
//
// Parameters
//   DIV_BITS  prescaler width; one scan step every 2**DIV_BITS clocks
//   BLANK     all-anodes-off clocks after each step, 1 <= BLANK < 2**DIV_BITS
//
// Ports
//   clkin     in   board clock, rising edge
//   reset     in   synchronous, active-high
//   digits    in   [15:0] BCD value, [15:12] = leftmost digit (digit 3)
//   sign      in   1 = negative, digit 3 shows a minus sign
//   blank_lz  in   1 = blank leading zeros
//   seg       out  [6:0] {g,f,e,d,c,b,a}, active-low, registered
//   dp        out  decimal point, active-low, always off
//   an        out  [3:0] anode enables, active-low, registered
//   tick      out  one-cycle pulse in the last prescaler cycle of each step
// -----------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int DIV_BITS = 13,
    parameter int BLANK    = 16
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        sign,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        tick
);

    localparam logic [DIV_BITS-1:0] CNT_MAX = {DIV_BITS{1'b1}};
    localparam logic [DIV_BITS-1:0] CNT_ONE = DIV_BITS'(1);
    // The anode register is loaded one edge early, so the digit lights
    // exactly in the cycle where cnt == BLANK.
    localparam logic [DIV_BITS-1:0] AN_ON_AT = DIV_BITS'(BLANK - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_BITS-1:0] cnt;
    logic [1:0]          idx;
    logic                armed;        // set by the first tick after reset
    logic [15:0]         snap_digits;
    logic                snap_sign;
    logic                snap_blz;

    // ------------------------------------------------------------------------
    // Next-digit selection
    // ------------------------------------------------------------------------
    logic [1:0]  idx_next;
    logic [15:0] src_digits;
    logic        src_sign;
    logic        src_blz;
    logic [3:0]  d3, d2, d1, d0;
    logic        lead3, lead2;         // every digit from 3 down is 0 or minus
    logic [6:0]  seg_next;
    logic [3:0]  an_on;

    // BCD to active-low segment pattern. Codes 10-15 are not valid BCD and
    // show 'E'.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_ERR;
        endcase
        return p;
    endfunction

    assign tick     = (cnt == CNT_MAX);
    assign idx_next = idx + 2'd1;
    assign an_on    = ~(4'b0001 << idx);
    assign dp       = 1'b1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        src_digits = snap_digits;
        src_sign   = snap_sign;
        src_blz    = snap_blz;
        seg_next   = SEG_BLANK;

        // The step from idx 3 to idx 0 is also the edge that takes the
        // snapshot. Digit 0 of the new frame must come from the value being
        // captured, not from the old snapshot.
        if (idx == 2'd3) begin
            src_digits = digits;
            src_sign   = sign;
            src_blz    = blank_lz;
        end

        d3 = src_digits[15:12];
        d2 = src_digits[11:8];
        d1 = src_digits[7:4];
        d0 = src_digits[3:0];

        // A minus counts as a leading zero for the digits to its right. A
        // nonzero digit (including an 'E') stops the blanking.
        lead3 = src_sign | (d3 == 4'd0);
        lead2 = lead3 & (d2 == 4'd0);

        case (idx_next)
            2'd0: seg_next = bcd_to_seg(d0);
            2'd1: seg_next = (src_blz && lead2 && d1 == 4'd0) ? SEG_BLANK
                                                              : bcd_to_seg(d1);
            2'd2: seg_next = (src_blz && lead3 && d2 == 4'd0) ? SEG_BLANK
                                                              : bcd_to_seg(d2);
            2'd3: begin
                if (src_sign)
                    seg_next = SEG_MINUS;
                else if (src_blz && d3 == 4'd0)
                    seg_next = SEG_BLANK;
                else
                    seg_next = bcd_to_seg(d3);
            end
            default: seg_next = SEG_BLANK;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            cnt         <= '0;
            idx         <= 2'd3;
            armed       <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= 4'b1111;
            snap_digits <= '0;
            snap_sign   <= 1'b0;
            snap_blz    <= 1'b0;
        end else begin
            cnt <= cnt + CNT_ONE;

            if (tick) begin
                idx   <= idx_next;
                armed <= 1'b1;
                seg   <= seg_next;
                an    <= 4'b1111;
                if (idx == 2'd3) begin
                    snap_digits <= digits;
                    snap_sign   <= sign;
                    snap_blz    <= blank_lz;
                end
            end else if (armed && cnt == AN_ON_AT) begin
                // Until the first tick after reset no digit has been selected.
                // The anodes stay dark during that time.
                an <= an_on;
            end
        end
    end

endmodule
